// File: rtl/eda_img_loader.sv
// eda_img_loader: accepts a raster pixel stream, drives the pixel RAM write port and
// holds the frame for the window scanner until it is released.
module eda_img_loader #(
    parameter int M           = 16,
    parameter int N           = 16,
    parameter int PIXEL_WIDTH = 8,
    parameter int I_WIDTH     = $clog2(M),
    parameter int J_WIDTH     = $clog2(N),
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   img_release,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_sof,
    input  logic                   s_eol,
    output logic                   write_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   img_valid,
    output logic                   err_sof,
    output logic                   err_eol
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, LOAD, FULL} state_t;
    state_t             state;
    logic [I_WIDTH-1:0] row;
    logic [J_WIDTH-1:0] col;
    logic               take;
    logic               col_last;
    logic               last_px;
    logic [I_WIDTH-1:0] er;
    logic [J_WIDTH-1:0] ec;
    assign s_ready  = (state == WAIT_SOF) || (state == LOAD);
    assign busy     = s_ready;
    // SOF always lands at pixel (0,0), whether it opens the frame or restarts it
    assign take     = s_valid && s_ready && (s_sof || state == LOAD);
    assign er       = s_sof ? '0 : row;
    assign ec       = s_sof ? '0 : col;
    assign col_last = (ec == J_WIDTH'(N - 1));
    assign last_px  = col_last && (er == I_WIDTH'(M - 1));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            write_en   <= 1'b0;
            wr_addr    <= '0;
            pixel_in   <= '0;
            frame_done <= 1'b0;
            img_valid  <= 1'b0;
            err_sof    <= 1'b0;
            err_eol    <= 1'b0;
        end else begin
            write_en   <= take;
            frame_done <= 1'b0;
            if (take) begin
                wr_addr  <= {er, ec};
                pixel_in <= s_data;
                col      <= ec + 1'b1;
                row      <= er + I_WIDTH'(col_last);
                if (s_sof && state == LOAD) err_sof <= 1'b1;
                if (s_eol != col_last) err_eol <= 1'b1;
                state    <= last_px ? FULL : LOAD;
            end
            if (state == IDLE && start) begin
                state   <= WAIT_SOF;
                err_sof <= 1'b0;
                err_eol <= 1'b0;
            end
            // img_valid trails the FULL transition by one cycle so it aligns with the last write landing
            if (state == FULL && !img_valid) begin
                img_valid  <= 1'b1;
                frame_done <= 1'b1;
            end
            if (state == FULL && img_valid && img_release) begin
                state     <= IDLE;
                img_valid <= 1'b0;
            end
        end
    end
endmodule
